// File: rtl/lfm_output_reg_pkg.sv
// Shared definitions for the LFM output register and its phase accumulator:
// FSM encoding, sine ROM geometry, pad code and the sine table generator.
package lfm_output_reg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2
   } lfm_state_e;

   localparam int LFM_ROM_ADDR_W = 12;
   localparam int LFM_ROM_DEPTH  = 1 << LFM_ROM_ADDR_W;
   localparam int LFM_SAMPLE_W   = 12;
   localparam logic [LFM_SAMPLE_W-1:0] LFM_MIDSCALE = 12'd2048;

   // Offset-binary sine sample for one table entry (Bhaskara I approximation,
   // integer only so it folds to constants at elaboration). The lower half of
   // the address range is the positive lobe, the upper half the negative one.
   function automatic logic [31:0] lfm_sin_sample(input int unsigned addr,
                                                  input int unsigned addr_w,
                                                  input int unsigned sample_w);
      longint half;
      longint mid;
      longint amp;
      longint p;
      longint q;
      longint num;
      longint den;
      longint mag;
      half = longint'(1) << (addr_w - 1);
      mid  = longint'(1) << (sample_w - 1);
      amp  = mid - 1;
      p    = longint'(addr) % half;
      q    = p * (half - p);
      num  = 16 * amp * q;
      den  = 5 * half * half - 4 * q;
      mag  = (num + den / 2) / den;
      if (longint'(addr) >= half) return 32'(mid - mag);
      return 32'(mid + mag);
   endfunction

endpackage

// File: rtl/lfm_output_reg_sin_rom.sv
// Synchronous sine ROM: one registered read per clock. The table is built at
// elaboration from the shared generator so synthesis maps it to a ROM.
module sin_rom
   import lfm_output_reg_pkg::*;
#(
   parameter int ADDR_WIDTH   = LFM_ROM_ADDR_W,
   parameter int SAMPLE_WIDTH = LFM_SAMPLE_W
) (
   input  logic                    clk,
   input  logic [ADDR_WIDTH-1:0]   addr,
   output logic [SAMPLE_WIDTH-1:0] data
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [SAMPLE_WIDTH-1:0] rom_tbl [DEPTH];
   logic [SAMPLE_WIDTH-1:0] data_d;
   logic [SAMPLE_WIDTH-1:0] data_q;

   for (genvar i = 0; i < DEPTH; i++) begin : g_tbl
      assign rom_tbl[i] = SAMPLE_WIDTH'(lfm_sin_sample(i, ADDR_WIDTH, SAMPLE_WIDTH));
   end

   // Table lookup for the address presented this cycle.
   always_comb begin
      data_d = rom_tbl[addr];
   end

   // Read register; no reset needed on ROM output data.
   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

   assign data = data_q;

endmodule

// File: rtl/lfm_output_reg.sv
// LFM output register: frames the accumulator address stream, converts each
// address to a sine sample, packs LANES samples per DAC word and buffers the
// words in a FIFO presented to the DAC under valid/ready.
module lfm_output_reg
   import lfm_output_reg_pkg::*;
#(
   parameter int ADDR_WIDTH   = LFM_ROM_ADDR_W,
   parameter int SAMPLE_WIDTH = LFM_SAMPLE_W,
   parameter int LANES        = 4,
   parameter int FIFO_DEPTH   = 64,
   parameter logic [SAMPLE_WIDTH-1:0] MIDSCALE = LFM_MIDSCALE
) (
   input  logic                          CLK,
   input  logic                          RESET_N,
   input  logic [ADDR_WIDTH-1:0]         ROM_ADDRESS,
   input  logic                          SIGN_START_CALC,
   input  logic                          SIGN_STOP_CALC,
   output logic                          OUT_REG_READY,
   output logic [LANES*SAMPLE_WIDTH-1:0] DAC_DATA,
   output logic                          DAC_VALID,
   output logic                          DAC_LAST,
   input  logic                          DAC_READY,
   output logic                          OVERFLOW
);
   localparam int WORD_W = LANES * SAMPLE_WIDTH;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

   lfm_state_e              state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cap_addr_q, cap_addr_d;
   logic                    cap_vld_q, cap_vld_d, cap_last_q, cap_last_d;
   logic                    rom_vld_q, rom_vld_d, rom_last_q, rom_last_d;
   logic [SAMPLE_WIDTH-1:0] rom_data;
   logic [WORD_W-1:0]       pack_q, pack_d, pack_ins;
   logic [LANE_W-1:0]       lane_q, lane_d;
   logic [WORD_W-1:0]       wr_word_q, wr_word_d;
   logic                    wr_vld_q, wr_vld_d, wr_last_q, wr_last_d;
   logic [WORD_W:0]         mem [FIFO_DEPTH];
   logic [PTR_W:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic                    fifo_empty, fifo_full, push, pop, start_clr;
   logic [WORD_W-1:0]       dac_data_q, dac_data_d;
   logic                    dac_valid_q, dac_valid_d, dac_last_q, dac_last_d;
   logic                    ovf_q, ovf_d, ready_q, ready_d;

   assign start_clr = (state_q == ST_IDLE) && SIGN_START_CALC;

   // Package FSM and address capture; the input stream is never throttled.
   always_comb begin
      state_d    = state_q;
      cap_vld_d  = 1'b0;
      cap_last_d = 1'b0;
      cap_addr_d = cap_addr_q;
      case (state_q)
         ST_IDLE: begin
            if (SIGN_START_CALC) state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            cap_vld_d  = 1'b1;
            cap_addr_d = ROM_ADDRESS;
            cap_last_d = SIGN_STOP_CALC;
            if (SIGN_STOP_CALC) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!cap_vld_q && !rom_vld_q && !wr_vld_q && fifo_empty) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   sin_rom #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .SAMPLE_WIDTH(SAMPLE_WIDTH)
   ) u_sin_rom (
      .clk (CLK),
      .addr(cap_addr_q),
      .data(rom_data)
   );

   // Lane packer: fill lanes in order, emit when full or on the last sample
   // with the unused upper lanes left at the pad code.
   always_comb begin
      rom_vld_d  = cap_vld_q;
      rom_last_d = cap_last_q;
      pack_d     = pack_q;
      lane_d     = lane_q;
      wr_vld_d   = 1'b0;
      wr_last_d  = 1'b0;
      wr_word_d  = wr_word_q;
      pack_ins   = pack_q;
      pack_ins[lane_q*SAMPLE_WIDTH +: SAMPLE_WIDTH] = rom_data;
      if (start_clr) begin
         pack_d = {LANES{MIDSCALE}};
         lane_d = '0;
      end else if (rom_vld_q) begin
         if (rom_last_q || (lane_q == LANE_W'(LANES - 1))) begin
            wr_vld_d  = 1'b1;
            wr_last_d = rom_last_q;
            wr_word_d = pack_ins;
            pack_d    = {LANES{MIDSCALE}};
            lane_d    = '0;
         end else begin
            pack_d = pack_ins;
            lane_d = lane_q + 1'b1;
         end
      end
   end

   // FIFO pointers, registered head presentation, overflow and ready flags.
   // The head becomes visible one cycle after it is written; a write while
   // full only succeeds when the DAC frees the head slot on the same edge.
   always_comb begin
      fifo_empty  = (wr_ptr_q == rd_ptr_q);
      fifo_full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
      pop         = dac_valid_q && DAC_READY;
      push        = wr_vld_q && (!fifo_full || pop);
      rd_ptr_d    = rd_ptr_q + (PTR_W+1)'(pop);
      wr_ptr_d    = wr_ptr_q + (PTR_W+1)'(push);
      dac_valid_d = (wr_ptr_q != rd_ptr_d);
      dac_data_d  = dac_data_q;
      dac_last_d  = dac_last_q;
      if (dac_valid_d) {dac_last_d, dac_data_d} = mem[rd_ptr_d[PTR_W-1:0]];
      ovf_d = ovf_q;
      if (start_clr) ovf_d = 1'b0;
      else if (wr_vld_q && !push) ovf_d = 1'b1;
      ready_d = (state_q == ST_IDLE) && fifo_empty && !SIGN_START_CALC;
   end

   // Control and output registers with asynchronous reset.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= ST_IDLE;
         cap_vld_q   <= 1'b0;
         cap_last_q  <= 1'b0;
         rom_vld_q   <= 1'b0;
         rom_last_q  <= 1'b0;
         pack_q      <= {LANES{MIDSCALE}};
         lane_q      <= '0;
         wr_vld_q    <= 1'b0;
         wr_last_q   <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         dac_data_q  <= '0;
         dac_valid_q <= 1'b0;
         dac_last_q  <= 1'b0;
         ovf_q       <= 1'b0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cap_vld_q   <= cap_vld_d;
         cap_last_q  <= cap_last_d;
         rom_vld_q   <= rom_vld_d;
         rom_last_q  <= rom_last_d;
         pack_q      <= pack_d;
         lane_q      <= lane_d;
         wr_vld_q    <= wr_vld_d;
         wr_last_q   <= wr_last_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         dac_data_q  <= dac_data_d;
         dac_valid_q <= dac_valid_d;
         dac_last_q  <= dac_last_d;
         ovf_q       <= ovf_d;
         ready_q     <= ready_d;
      end
   end

   // Datapath registers and FIFO storage; qualified by the valid flags above.
   always_ff @(posedge CLK) begin
      cap_addr_q <= cap_addr_d;
      wr_word_q  <= wr_word_d;
      if (push) mem[wr_ptr_q[PTR_W-1:0]] <= {wr_last_q, wr_word_q};
   end

   assign OUT_REG_READY = ready_q;
   assign DAC_DATA      = dac_data_q;
   assign DAC_VALID     = dac_valid_q;
   assign DAC_LAST      = dac_last_q;
   assign OVERFLOW      = ovf_q;

endmodule

// File: tb/tb_lfm_output_reg.sv
// Bench for lfm_output_reg: directed packages plus randomized packages scored
// against a word-level model of the expected DAC stream.
module tb_lfm_output_reg;
   localparam int LANES = 4;
   localparam int DEPTH = 64;
   localparam logic [11:0] MID = 12'd2048;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic [11:0] ROM_ADDRESS = '0;
   logic        START = 1'b0;
   logic        STOP = 1'b0;
   logic        DAC_READY = 1'b0;
   logic        OUT_REG_READY, DAC_VALID, DAC_LAST, OVERFLOW;
   logic [47:0] DAC_DATA;

   lfm_output_reg #(
      .ADDR_WIDTH(12), .SAMPLE_WIDTH(12), .LANES(LANES), .FIFO_DEPTH(DEPTH), .MIDSCALE(MID)
   ) dut (
      .CLK(CLK), .RESET_N(RESET_N), .ROM_ADDRESS(ROM_ADDRESS),
      .SIGN_START_CALC(START), .SIGN_STOP_CALC(STOP), .OUT_REG_READY(OUT_REG_READY),
      .DAC_DATA(DAC_DATA), .DAC_VALID(DAC_VALID), .DAC_LAST(DAC_LAST),
      .DAC_READY(DAC_READY), .OVERFLOW(OVERFLOW)
   );

   always #5 CLK = ~CLK;

   int          n_tests = 0;
   int          n_fail = 0;
   longint      cyc = 0;
   int          ready_mode = 1;   // 0: low, 1: high, 2: random
   logic [48:0] exp_q[$];         // {last, data}
   logic [48:0] mon_e;
   logic [47:0] prev_data;
   bit          prev_hold = 0;
   int          words_seen = 0;
   int          last_seen = 0;
   bit          lat_armed = 0;
   longint      lat_cap = 0;
   longint      lat_seen = -1;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference sine table: positive lobe for the lower half of the phase
   // circle, negative lobe for the upper half, Bhaskara approximation with
   // round-half-up, offset binary around 2048.
   function automatic logic [11:0] ref_sin(input int a);
      longint p, x, den, mag;
      p   = a % 2048;
      x   = p * (2048 - p);
      den = 5 * 2048 * 2048 - 4 * x;
      mag = (2 * 16 * 2047 * x + den) / (2 * den);
      return (a < 2048) ? 12'(2048 + mag) : 12'(2048 - mag);
   endfunction

   // Expected DAC words for a package; words beyond max_words are lost.
   task automatic model_pkg(input int a[$], input int max_words);
      logic [47:0] w;
      int lane;
      int nw;
      w = {LANES{MID}};
      lane = 0;
      nw = 0;
      for (int i = 0; i < a.size(); i++) begin
         w[lane*12 +: 12] = ref_sin(a[i]);
         lane++;
         if (lane == LANES || i == a.size() - 1) begin
            if (nw < max_words) exp_q.push_back({(i == a.size() - 1), w});
            nw++;
            w = {LANES{MID}};
            lane = 0;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge CLK);
         #1;
         case (ready_mode)
            0:       DAC_READY = 1'b0;
            1:       DAC_READY = 1'b1;
            default: DAC_READY = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Scoreboard: every accepted word must match the model head; a word held
   // without READY must stay put.
   always @(negedge CLK) begin
      if (RESET_N) begin
         if (prev_hold) begin
            check("hold_valid", DAC_VALID, 1);
            check("hold_data", DAC_DATA, prev_data);
         end
         prev_hold = DAC_VALID && !DAC_READY;
         prev_data = DAC_DATA;
         if (DAC_VALID && lat_armed) begin
            lat_seen  = cyc - lat_cap;
            lat_armed = 0;
         end
         if (DAC_VALID && DAC_READY) begin
            words_seen++;
            if (DAC_LAST) last_seen++;
            check("ready_low_while_busy", OUT_REG_READY, 0);
            check("word_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check("dac_data", DAC_DATA, mon_e[47:0]);
               check("dac_last", DAC_LAST, mon_e[48]);
            end
         end
      end else begin
         prev_hold = 0;
      end
   end

   task automatic send_pkg(input int a[$], input bit noisy, input bit drain_start);
      @(posedge CLK); #1;
      START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      check("ready_low_after_start", OUT_REG_READY, 0);
      check("overflow_cleared", OVERFLOW, 0);
      lat_cap   = cyc + 1;
      lat_seen  = -1;
      lat_armed = 1;
      for (int i = 0; i < a.size(); i++) begin
         ROM_ADDRESS = 12'(a[i]);
         STOP  = (i == a.size() - 1);
         START = noisy && ($urandom_range(0, 3) == 0);
         @(posedge CLK); #1;
      end
      STOP = 1'b0;
      START = drain_start;
      ROM_ADDRESS = 12'($urandom_range(0, 4095));
      @(posedge CLK); #1;
      START = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || !OUT_REG_READY) && k < budget) begin
         @(posedge CLK); #1;
         k++;
      end
      check("pkg_complete", (exp_q.size() == 0) && OUT_REG_READY, 1);
   endtask

   task automatic run_pkg(input int a[$], input bit noisy, input bit drain_start);
      model_pkg(a, 1 << 20);
      send_pkg(a, noisy, drain_start);
      wait_done(3000);
      if (a.size() >= LANES) check("first_word_latency", lat_seen, LANES + 3);
   endtask

   initial begin
      int a[$];
      int ws, ls;
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a[$];
      int ws, ls;
      // 1: reset values and ready after release
      repeat (2) @(posedge CLK);
      #1;
      check("rst_ready", OUT_REG_READY, 0);
      check("rst_valid", DAC_VALID, 0);
      check("rst_data", DAC_DATA, 0);
      check("rst_last", DAC_LAST, 0);
      check("rst_overflow", OVERFLOW, 0);
      @(negedge CLK);
      RESET_N = 1'b1;
      @(posedge CLK); #1;
      check("ready_after_release", OUT_REG_READY, 1);
      check("valid_after_release", DAC_VALID, 0);

      // 2: one full word from fixed quadrant addresses
      a = '{0, 1024, 2048, 3072};
      exp_q.push_back({1'b1, 12'd1, 12'd2048, 12'd4095, 12'd2048});
      send_pkg(a, 0, 0);
      wait_done(500);
      check("quadrant_latency", lat_seen, LANES + 3);

      // 3: six samples -> full word plus padded last word
      a = {};
      for (int i = 0; i < 6; i++) a.push_back($urandom_range(0, 4095));
      run_pkg(a, 0, 0);

      // 4: FIFO overflow with DAC stalled
      ready_mode = 0;
      @(posedge CLK); #1;
      a = {};
      for (int i = 0; i < 300; i++) a.push_back($urandom_range(0, 4095));
      model_pkg(a, DEPTH);
      send_pkg(a, 0, 0);
      repeat (20) @(posedge CLK);
      #1;
      check("ovf_set", OVERFLOW, 1);
      check("ovf_valid_held", DAC_VALID, 1);
      check("ovf_ready_low", OUT_REG_READY, 0);
      ws = words_seen;
      ls = last_seen;
      ready_mode = 1;
      wait_done(2000);
      check("ovf_words_retained", words_seen - ws, DEPTH);
      check("ovf_no_last", last_seen - ls, 0);
      check("ovf_sticky", OVERFLOW, 1);

      // 6: single sample, START during drain ignored, overflow cleared
      a = '{1024};
      ws = words_seen;
      exp_q.push_back({1'b1, MID, MID, MID, 12'd4095});
      send_pkg(a, 0, 1);
      wait_done(500);
      repeat (20) @(posedge CLK);
      #1;
      check("single_one_word", words_seen - ws, 1);
      check("single_ready", OUT_REG_READY, 1);

      // 5: reset in the middle of a package
      ready_mode = 0;
      @(posedge CLK); #1;
      START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      for (int i = 0; i < 10; i++) begin
         ROM_ADDRESS = 12'($urandom_range(0, 4095));
         @(posedge CLK); #1;
      end
      #2;
      RESET_N = 1'b0;
      #1;
      check("midrst_valid", DAC_VALID, 0);
      check("midrst_data", DAC_DATA, 0);
      check("midrst_last", DAC_LAST, 0);
      check("midrst_ready", OUT_REG_READY, 0);
      check("midrst_overflow", OVERFLOW, 0);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RESET_N = 1'b1;
      ready_mode = 1;
      @(posedge CLK); #1;
      check("midrst_ready_after", OUT_REG_READY, 1);
      ws = words_seen;
      repeat (30) @(posedge CLK);
      #1;
      check("midrst_no_stale_valid", DAC_VALID, 0);
      check("midrst_no_stale_words", words_seen - ws, 0);

      // Randomized packages with random DAC backpressure
      ready_mode = 2;
      for (int p = 0; p < 25; p++) begin
         a = {};
         for (int i = 0; i < ((p == 0) ? 8 : $urandom_range(1, 40)); i++)
            a.push_back($urandom_range(0, 4095));
         run_pkg(a, 1, 1'($urandom_range(0, 1)));
      end
      ready_mode = 1;
      repeat (10) @(posedge CLK);
      #1;
      check("final_overflow", OVERFLOW, 0);
      check("final_queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
